// File: rtl/shim_cfg_stable_sync.sv
// Multi-channel config shim that carries quasi-static fields across a clock domain crossing.
// A field is committed to dout only after it has been seen unchanged for STABLE_CYCLES cycles.
module shim_cfg_stable_sync #(
    parameter int NUM_CH        = 5,
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4,
    parameter logic [NUM_CH*WIDTH-1:0] DEFAULTS = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic                    lock,
    output logic [NUM_CH*WIDTH-1:0] dout,
    output logic [NUM_CH-1:0]       stable,
    output logic [NUM_CH-1:0]       update
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] s1;
        logic [WIDTH-1:0] s2;
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] held;
        logic [CW-1:0]    cnt;
        logic             upd;
        logic             commit;

        // Only prev is ever copied into held, and only after cnt proves it has not
        // moved for STABLE_CYCLES+1 samples, so incoherent bit skew never reaches dout.
        assign commit = stable[i] && !lock && (prev != held);

        always_ff @(posedge clk) begin
            if (rst) begin
                s1   <= DEFAULTS[i*WIDTH +: WIDTH];
                s2   <= DEFAULTS[i*WIDTH +: WIDTH];
                prev <= DEFAULTS[i*WIDTH +: WIDTH];
                held <= DEFAULTS[i*WIDTH +: WIDTH];
                cnt  <= '0;
                upd  <= 1'b0;
            end else begin
                s1   <= din[i*WIDTH +: WIDTH];
                s2   <= s1;
                prev <= s2;
                if (s2 != prev) begin
                    cnt <= '0;
                end else if (cnt < CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
                if (commit) begin
                    held <= prev;
                end
                upd <= commit;
            end
        end

        assign stable[i]                 = (cnt == CNT_MAX);
        assign update[i]                 = upd;
        assign dout[i*WIDTH +: WIDTH]    = held;
    end

endmodule
